// File: rtl/drv_7seg_pkg.sv
// Shared constants for the 7-segment display driver.
// Segment order is {a,b,c,d,e,f,g,dp}, 1 = segment on.
package drv_7seg_pkg;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   localparam logic [7:0] SEG_ALL_ON  = 8'hFF;
   localparam logic [7:0] SEG_ALL_OFF = 8'h00;

   // a..g patterns for hex digits 0..F
   localparam logic [6:0] HEX_TBL [0:15] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

endpackage

// File: rtl/drv_7seg_hex_dec.sv
// Combinational hex digit to a..g segment decoder.
// Only instantiated when DRV_7SEG_HEX_EN is defined.
module drv_7seg_hex_dec
   import drv_7seg_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   // table lookup, one pattern per nibble value
   always_comb begin
      seg_o = HEX_TBL[digit_i];
   end

endmodule

// File: rtl/seven_seg_drv.sv
// Registered 7-segment driver with lamp test and blanking.
// Optional hex-decode path enabled by macro DRV_7SEG_HEX_EN.
module seven_seg_drv
   import drv_7seg_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b0
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lt,
   input  logic       blank,
   input  logic       hex_mode,
   input  logic [7:0] inbus,
   output logic [7:0] outbus
);

   localparam logic [7:0] RST_VAL =
      SEG_ACTIVE_LOW ? ~SEG_ALL_OFF : SEG_ALL_OFF;

   logic [7:0] seg_d;
   logic [7:0] pin_d;
   logic [7:0] outbus_q;

`ifdef DRV_7SEG_HEX_EN
   logic [6:0] hex_seg;

   drv_7seg_hex_dec u_hex_dec (
      .digit_i (inbus[3:0]),
      .seg_o   (hex_seg)
   );

   // lamp test beats blank beats hex decode beats raw
   always_comb begin
      seg_d = inbus;
      if (!lt) begin
         seg_d = SEG_ALL_ON;
      end else if (blank) begin
         seg_d = SEG_ALL_OFF;
      end else if (hex_mode) begin
         seg_d = {hex_seg, inbus[4]};
      end
   end
`else
   logic hex_mode_unused;
   assign hex_mode_unused = hex_mode;

   // lamp test beats blank beats raw pass-through
   always_comb begin
      seg_d = inbus;
      if (!lt) begin
         seg_d = SEG_ALL_ON;
      end else if (blank) begin
         seg_d = SEG_ALL_OFF;
      end
   end
`endif

   // apply pin polarity before the register
   always_comb begin
      pin_d = SEG_ACTIVE_LOW ? ~seg_d : seg_d;
   end

   // output register, reset drives all segments off
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outbus_q <= RST_VAL;
      end else begin
         outbus_q <= pin_d;
      end
   end

   assign outbus = outbus_q;

endmodule

// File: tb/tb_seven_seg_drv.sv
// Self-checking bench for seven_seg_drv, both pin polarities.
// Hex vectors included when DRV_7SEG_HEX_EN is defined.
module tb_seven_seg_drv;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lt = 1'b1;
   logic       blank = 1'b0;
   logic       hex_mode = 1'b0;
   logic [7:0] inbus = 8'h00;
   logic [7:0] ob_hi;
   logic [7:0] ob_lo;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       lt;
      logic       blank;
      logic       hm;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] q_hi[$];
   logic [7:0] q_lo[$];
   logic [7:0] digs [0:9] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
      8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6
   };

   seven_seg_drv #(.SEG_ACTIVE_LOW(1'b0)) u_hi (
      .clk      (clk),
      .rst_n    (rst_n),
      .lt       (lt),
      .blank    (blank),
      .hex_mode (hex_mode),
      .inbus    (inbus),
      .outbus   (ob_hi)
   );

   seven_seg_drv #(.SEG_ACTIVE_LOW(1'b1)) u_lo (
      .clk      (clk),
      .rst_n    (rst_n),
      .lt       (lt),
      .blank    (blank),
      .hex_mode (hex_mode),
      .inbus    (inbus),
      .outbus   (ob_lo)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [7:0] act,
                      logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step(string name, logic r, logic l,
                       logic b, logic h, logic [7:0] d,
                       logic [7:0] e);
      @(negedge clk);
      rst_n    = r;
      lt       = l;
      blank    = b;
      hex_mode = h;
      inbus    = d;
      q_hi.push_back(e);
      q_lo.push_back(~e);
      @(posedge clk);
      #1;
      chk({name, "/hi"}, ob_hi, q_hi.pop_front());
      chk({name, "/lo"}, ob_lo, q_lo.pop_front());
   endtask

   initial begin
      step("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 8'h00);
      step("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 8'h00);

      for (int i = 0; i < 10; i++) begin
         tbl.push_back('{1'b0, 1'b0, 1'b0, digs[i], 8'hFF});
         tbl.push_back('{1'b1, 1'b0, 1'b0, digs[i], digs[i]});
      end
      tbl.push_back('{1'b0, 1'b1, 1'b0, 8'hFC, 8'hFF});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 8'hFC, 8'h00});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 8'hFC, 8'hFC});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h1A, 8'hFF});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h1A, 8'h00});
`ifdef DRV_7SEG_HEX_EN
      tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h1A, 8'hEF});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h03, 8'hF2});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h08, 8'hFE});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h1F, 8'h8F});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h0B, 8'h3E});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h03, 8'h03});
`else
      tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h03, 8'h03});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h1A, 8'h1A});
`endif

      foreach (tbl[i]) begin
         step($sformatf("vec%0d", i), 1'b1, tbl[i].lt,
              tbl[i].blank, tbl[i].hm, tbl[i].din,
              tbl[i].exp);
      end

      // reset mid-run, then one cycle to valid output
      step("midrst", 1'b0, 1'b1, 1'b0, 1'b0, 8'hB6, 8'h00);
      step("resume", 1'b1, 1'b1, 1'b0, 1'b0, 8'hB6, 8'hB6);

      // input changes between edges must not reach outbus
      lt    = 1'b0;
      inbus = 8'h11;
      #3;
      chk("hold/hi", ob_hi, 8'hB6);
      chk("hold/lo", ob_lo, 8'h49);
      step("after", 1'b1, 1'b1, 1'b0, 1'b0, 8'h60, 8'h60);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
